// File: rtl/mem_access_unit.sv
`default_nettype none
// ============================================================================
//  Module      : mem_access_unit
//  Description : Load/store stage following the ALU in the multicycle MIPS
//                datapath. Runs one Avalon-style data-bus transaction per
//                accepted start: byte-lane selection, sign/zero extension,
//                LWL/LWR merging, alignment checks, waitrequest stalls and an
//                optional stall timeout. Returns the rt write-back value and
//                a one-cycle done pulse for the control FSM.
//  Ports       : clk, reset           - clock, synchronous active-high reset
//                start_i, op_i        - request strobe and ALU opcode
//                addr_i               - effective byte address
//                store_data_i         - rt value for stores
//                rt_old_i             - rt value merged by LWL/LWR
//                bus_*                - Avalon-style data-bus master
//                load_data_o          - write-back value of the last load
//                done_o, busy_o       - completion pulse / not-idle flag
//                addr_error_o         - misaligned request (with done)
//                bus_error_o          - stall timeout abort (with done)
//  Revision    : 1.0 - initial release
// ============================================================================
module mem_access_unit #(
    parameter int unsigned WAIT_TIMEOUT = 0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start_i,
    input  logic [6:0]  op_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] store_data_i,
    input  logic [31:0] rt_old_i,
    output logic [31:0] bus_address_o,
    output logic        bus_read_o,
    output logic        bus_write_o,
    output logic [3:0]  bus_byteenable_o,
    output logic [31:0] bus_writedata_o,
    input  logic [31:0] bus_readdata_i,
    input  logic        bus_waitrequest_i,
    output logic [31:0] load_data_o,
    output logic        done_o,
    output logic        busy_o,
    output logic        addr_error_o,
    output logic        bus_error_o
);

    // ALU opcode codes of the memory instructions
    localparam logic [6:0] c_op_lb  = 7'd42;
    localparam logic [6:0] c_op_lbu = 7'd43;
    localparam logic [6:0] c_op_lh  = 7'd44;
    localparam logic [6:0] c_op_lhu = 7'd45;
    localparam logic [6:0] c_op_lw  = 7'd47;
    localparam logic [6:0] c_op_lwl = 7'd48;
    localparam logic [6:0] c_op_lwr = 7'd49;
    localparam logic [6:0] c_op_sb  = 7'd50;
    localparam logic [6:0] c_op_sh  = 7'd51;
    localparam logic [6:0] c_op_sw  = 7'd52;

    // Last stalled-cycle count before the abort fires (only meaningful when
    // WAIT_TIMEOUT is non-zero)
    localparam logic [31:0] c_tmo_last = 32'(WAIT_TIMEOUT - 32'd1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_FIN  = 2'd2
    } state_t;

    state_t      state_q;
    logic [31:0] bus_address_q;
    logic        bus_read_q;
    logic        bus_write_q;
    logic [3:0]  bus_byteenable_q;
    logic [31:0] bus_writedata_q;
    logic [31:0] load_data_q;
    logic [31:0] load_data_d;
    logic        done_q;
    logic        busy_q;
    logic        addr_error_q;
    logic        bus_error_q;
    logic [6:0]  op_q;
    logic [1:0]  lane_q;
    logic [31:0] rt_q;
    logic [31:0] tmo_cnt_q;

    // ------------------------------------------------------------------
    // Request decode (evaluated against the live inputs while IDLE)
    // ------------------------------------------------------------------
    logic        w_is_load;
    logic        w_is_store;
    logic        w_misaligned;
    logic [3:0]  w_be;
    logic [31:0] w_wdata;

    always_comb begin
        w_is_load    = 1'b0;
        w_is_store   = 1'b0;
        w_misaligned = 1'b0;
        w_be         = 4'b1111;
        w_wdata      = store_data_i;
        case (op_i)
            c_op_lb, c_op_lbu, c_op_lwl, c_op_lwr: begin
                w_is_load = 1'b1;
            end
            c_op_lh, c_op_lhu: begin
                w_is_load    = 1'b1;
                w_misaligned = addr_i[0];
            end
            c_op_lw: begin
                w_is_load    = 1'b1;
                w_misaligned = |addr_i[1:0];
            end
            c_op_sb: begin
                w_is_store = 1'b1;
                w_wdata    = {4{store_data_i[7:0]}};
                w_be       = 4'b0001 << addr_i[1:0];
            end
            c_op_sh: begin
                w_is_store   = 1'b1;
                w_misaligned = addr_i[0];
                w_wdata      = {2{store_data_i[15:0]}};
                w_be         = addr_i[1] ? 4'b1100 : 4'b0011;
            end
            c_op_sw: begin
                w_is_store   = 1'b1;
                w_misaligned = |addr_i[1:0];
            end
            default: ;
        endcase
    end

    // ------------------------------------------------------------------
    // Load formatting from the bus word, using the latched request
    // ------------------------------------------------------------------
    logic [7:0]  w_byte;
    logic [15:0] w_half;
    logic [31:0] w_m;

    always_comb begin
        w_m = bus_readdata_i;
        case (lane_q)
            2'd0:    w_byte = w_m[7:0];
            2'd1:    w_byte = w_m[15:8];
            2'd2:    w_byte = w_m[23:16];
            default: w_byte = w_m[31:24];
        endcase
        w_half = lane_q[1] ? w_m[31:16] : w_m[15:0];

        load_data_d = load_data_q;
        case (op_q)
            c_op_lb:  load_data_d = {{24{w_byte[7]}}, w_byte};
            c_op_lbu: load_data_d = {24'd0, w_byte};
            c_op_lh:  load_data_d = {{16{w_half[15]}}, w_half};
            c_op_lhu: load_data_d = {16'd0, w_half};
            c_op_lw:  load_data_d = w_m;
            // LWL fills the upper bytes of rt from the addressed byte down
            c_op_lwl: begin
                case (lane_q)
                    2'd0:    load_data_d = {w_m[7:0],  rt_q[23:0]};
                    2'd1:    load_data_d = {w_m[15:0], rt_q[15:0]};
                    2'd2:    load_data_d = {w_m[23:0], rt_q[7:0]};
                    default: load_data_d = w_m;
                endcase
            end
            // LWR fills the lower bytes of rt from the addressed byte up
            c_op_lwr: begin
                case (lane_q)
                    2'd0:    load_data_d = w_m;
                    2'd1:    load_data_d = {rt_q[31:24], w_m[31:8]};
                    2'd2:    load_data_d = {rt_q[31:16], w_m[31:16]};
                    default: load_data_d = {rt_q[31:8],  w_m[31:24]};
                endcase
            end
            default: ;
        endcase
    end

    // ------------------------------------------------------------------
    // Control FSM with registered outputs
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q          <= S_IDLE;
            bus_address_q    <= 32'd0;
            bus_read_q       <= 1'b0;
            bus_write_q      <= 1'b0;
            bus_byteenable_q <= 4'd0;
            bus_writedata_q  <= 32'd0;
            load_data_q      <= 32'd0;
            done_q           <= 1'b0;
            busy_q           <= 1'b0;
            addr_error_q     <= 1'b0;
            bus_error_q      <= 1'b0;
            op_q             <= 7'd0;
            lane_q           <= 2'd0;
            rt_q             <= 32'd0;
            tmo_cnt_q        <= 32'd0;
        end else begin
            // Pulses default low; only the transition into FIN raises them
            done_q       <= 1'b0;
            addr_error_q <= 1'b0;
            bus_error_q  <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (start_i) begin
                        busy_q <= 1'b1;
                        if ((w_is_load || w_is_store) && !w_misaligned) begin
                            state_q          <= S_REQ;
                            bus_address_q    <= {addr_i[31:2], 2'b00};
                            bus_read_q       <= w_is_load;
                            bus_write_q      <= w_is_store;
                            bus_byteenable_q <= w_be;
                            bus_writedata_q  <= w_wdata;
                            op_q             <= op_i;
                            lane_q           <= addr_i[1:0];
                            rt_q             <= rt_old_i;
                            tmo_cnt_q        <= 32'd0;
                        end else begin
                            // Misaligned and non-memory ops skip the bus phase
                            state_q      <= S_FIN;
                            done_q       <= 1'b1;
                            addr_error_q <= w_misaligned;
                        end
                    end
                end
                S_REQ: begin
                    if (!bus_waitrequest_i) begin
                        state_q     <= S_FIN;
                        bus_read_q  <= 1'b0;
                        bus_write_q <= 1'b0;
                        done_q      <= 1'b1;
                        if (bus_read_q) begin
                            load_data_q <= load_data_d;
                        end
                    end else if ((WAIT_TIMEOUT != 0) && (tmo_cnt_q == c_tmo_last)) begin
                        state_q     <= S_FIN;
                        bus_read_q  <= 1'b0;
                        bus_write_q <= 1'b0;
                        done_q      <= 1'b1;
                        bus_error_q <= 1'b1;
                    end else begin
                        tmo_cnt_q <= tmo_cnt_q + 32'd1;
                    end
                end
                S_FIN: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                end
                default: begin
                    state_q     <= S_IDLE;
                    busy_q      <= 1'b0;
                    bus_read_q  <= 1'b0;
                    bus_write_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus_address_o    = bus_address_q;
    assign bus_read_o       = bus_read_q;
    assign bus_write_o      = bus_write_q;
    assign bus_byteenable_o = bus_byteenable_q;
    assign bus_writedata_o  = bus_writedata_q;
    assign load_data_o      = load_data_q;
    assign done_o           = done_q;
    assign busy_o           = busy_q;
    assign addr_error_o     = addr_error_q;
    assign bus_error_o      = bus_error_q;

endmodule
`default_nettype wire
